// File: rtl/gnn_pkg.sv
`default_nettype none
// ============================================================================
// Module : gnn_pkg
// Brief  : Shared widths, state encoding and helpers for the GNN layer scheduler
// Rev    : 1.0  initial release
// ============================================================================
package gnn_pkg;

    localparam int NUM_NODES = 4;
    localparam int X_W       = 6;
    localparam int Y_W       = 13;
    localparam int OUT_W     = 17;
    localparam int SUM_W     = 15;

    typedef logic signed [X_W-1:0]   x_t;
    typedef logic signed [Y_W-1:0]   y_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    localparam y_t Y_MAX = y_t'(13'h0FFF);
    localparam y_t Y_MIN = y_t'(13'h1000);

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_LOAD     = 4'd1;
    localparam state_t S_L1_ISSUE = 4'd2;
    localparam state_t S_L1_CAPT  = 4'd3;
    localparam state_t S_AGGR     = 4'd4;
    localparam state_t S_L2_ISSUE = 4'd5;
    localparam state_t S_L2_DRIVE = 4'd6;
    localparam state_t S_L2_CAPT  = 4'd7;
    localparam state_t S_OUT_WAIT = 4'd8;
    localparam state_t S_DONE     = 4'd9;

    // Neighbour set of one node: its adjacency row, plus itself when self-loops are enabled.
    function automatic logic [NUM_NODES-1:0] aggr_mask(
        input logic [15:0] adj_bits,
        input logic [1:0]  node,
        input logic        self_en
    );
        logic [NUM_NODES-1:0] m;
        m = adj_bits[4*int'(node) +: 4];
        if (self_en) begin
            m[node] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnn_layer_sched_if.sv
`default_nettype none
// ============================================================================
// Module : gnn_layer_sched_if
// Brief  : Feature-load, datapath and result buses of the GNN layer scheduler
// Rev    : 1.0  initial release
// ============================================================================
interface gnn_layer_sched_if;
    import gnn_pkg::*;

    logic feat_valid;
    logic feat_ready;
    x_t   feat_x0;
    x_t   feat_x1;
    x_t   feat_x2;
    x_t   feat_x3;

    logic dnn_in_ready;
    x_t   dnn_x0;
    x_t   dnn_x1;
    x_t   dnn_x2;
    x_t   dnn_x3;
    y_t   dnn_y4;
    y_t   dnn_y5;
    y_t   dnn_y6;
    y_t   dnn_y7;
    y_t   dnn_y4_aggr;
    y_t   dnn_y5_aggr;
    y_t   dnn_y6_aggr;
    y_t   dnn_y7_aggr;
    out_t dnn_out0;
    out_t dnn_out1;
    logic dnn_out_ready;

    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_node;
    out_t       res_out0;
    out_t       res_out1;

    modport master (
        input  feat_valid, feat_x0, feat_x1, feat_x2, feat_x3,
        input  dnn_y4, dnn_y5, dnn_y6, dnn_y7, dnn_out0, dnn_out1, dnn_out_ready,
        input  res_ready,
        output feat_ready,
        output dnn_in_ready, dnn_x0, dnn_x1, dnn_x2, dnn_x3,
        output dnn_y4_aggr, dnn_y5_aggr, dnn_y6_aggr, dnn_y7_aggr,
        output res_valid, res_node, res_out0, res_out1
    );

    modport slave (
        output feat_valid, feat_x0, feat_x1, feat_x2, feat_x3,
        output dnn_y4, dnn_y5, dnn_y6, dnn_y7, dnn_out0, dnn_out1, dnn_out_ready,
        output res_ready,
        input  feat_ready,
        input  dnn_in_ready, dnn_x0, dnn_x1, dnn_x2, dnn_x3,
        input  dnn_y4_aggr, dnn_y5_aggr, dnn_y6_aggr, dnn_y7_aggr,
        input  res_valid, res_node, res_out0, res_out1
    );

endinterface
`default_nettype wire

// File: rtl/gnn_aggr_unit.sv
`default_nettype none
// ============================================================================
// Module : gnn_aggr_unit
// Brief  : One lane of neighbour aggregation: masked 4-input sum, saturated to 13 bits
// Rev    : 1.0  initial release
// ============================================================================
module gnn_aggr_unit
    import gnn_pkg::*;
(
    input  y_t                   h0,
    input  y_t                   h1,
    input  y_t                   h2,
    input  y_t                   h3,
    input  logic [NUM_NODES-1:0] mask,
    output y_t                   sum
);

    localparam sum_t SUM_HI = sum_t'(15'sd4095);
    localparam sum_t SUM_LO = -sum_t'(15'sd4096);

    sum_t acc;

    // Four 13-bit terms cannot overflow 15 bits, so the clamp sees the exact sum.
    always_comb begin
        acc = '0;
        if (mask[0]) acc = acc + sum_t'(h0);
        if (mask[1]) acc = acc + sum_t'(h1);
        if (mask[2]) acc = acc + sum_t'(h2);
        if (mask[3]) acc = acc + sum_t'(h3);
    end

    always_comb begin
        if (acc > SUM_HI) begin
            sum = Y_MAX;
        end else if (acc < SUM_LO) begin
            sum = Y_MIN;
        end else begin
            sum = acc[Y_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module : gnn_layer_sched
// Brief  : Sequences one 4-node GNN pass: feature load, layer 1, aggregation, layer 2
// Rev    : 1.0  initial release
// ============================================================================
module gnn_layer_sched
    import gnn_pkg::*;
#(
    parameter bit AGGR_SELF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       adj,
    output logic              busy,
    output logic              done,
    output logic              proto_err,
    gnn_layer_sched_if.master bus
);

    state_t     state;
    logic [1:0] n;
    logic [15:0] adj_q;

    // Arrays are indexed [node][lane].
    x_t feat [NUM_NODES][NUM_NODES];
    y_t hid  [NUM_NODES][NUM_NODES];
    y_t agg  [NUM_NODES][NUM_NODES];

    x_t feat_beat [NUM_NODES];
    y_t l1_y      [NUM_NODES];
    y_t agg_sum   [NUM_NODES];
    logic [NUM_NODES-1:0] agg_mask;

    logic       res_valid_q;
    logic [1:0] res_node_q;
    out_t       res_out0_q;
    out_t       res_out1_q;
    logic       drive_x;

    assign feat_beat[0] = bus.feat_x0;
    assign feat_beat[1] = bus.feat_x1;
    assign feat_beat[2] = bus.feat_x2;
    assign feat_beat[3] = bus.feat_x3;

    assign l1_y[0] = bus.dnn_y4;
    assign l1_y[1] = bus.dnn_y5;
    assign l1_y[2] = bus.dnn_y6;
    assign l1_y[3] = bus.dnn_y7;

    assign agg_mask = aggr_mask(adj_q, n, AGGR_SELF);

    for (genvar l = 0; l < NUM_NODES; l++) begin : g_lane
        gnn_aggr_unit u_aggr (
            .h0   (hid[0][l]),
            .h1   (hid[1][l]),
            .h2   (hid[2][l]),
            .h3   (hid[3][l]),
            .mask (agg_mask),
            .sum  (agg_sum[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            n           <= 2'd0;
            adj_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            proto_err   <= 1'b0;
            res_valid_q <= 1'b0;
            res_node_q  <= 2'd0;
            res_out0_q  <= '0;
            res_out1_q  <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                for (int j = 0; j < NUM_NODES; j++) begin
                    feat[i][j] <= '0;
                    hid[i][j]  <= '0;
                    agg[i][j]  <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        adj_q <= adj;
                        n     <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.feat_valid) begin
                        for (int l = 0; l < NUM_NODES; l++) begin
                            feat[n][l] <= feat_beat[l];
                        end
                        n <= n + 2'd1;
                        if (n == 2'd3) begin
                            state <= S_L1_ISSUE;
                        end
                    end
                end
                S_L1_ISSUE: begin
                    state <= S_L1_CAPT;
                end
                S_L1_CAPT: begin
                    for (int l = 0; l < NUM_NODES; l++) begin
                        hid[n][l] <= l1_y[l];
                    end
                    n     <= n + 2'd1;
                    state <= (n == 2'd3) ? S_AGGR : S_L1_ISSUE;
                end
                S_AGGR: begin
                    for (int l = 0; l < NUM_NODES; l++) begin
                        agg[n][l] <= agg_sum[l];
                    end
                    n <= n + 2'd1;
                    if (n == 2'd3) begin
                        state <= S_L2_ISSUE;
                    end
                end
                S_L2_ISSUE: begin
                    state <= S_L2_DRIVE;
                end
                S_L2_DRIVE: begin
                    state <= S_L2_CAPT;
                end
                S_L2_CAPT: begin
                    // A datapath that is not ready here is flagged, but the result is still taken.
                    res_out0_q  <= bus.dnn_out0;
                    res_out1_q  <= bus.dnn_out1;
                    res_node_q  <= n;
                    res_valid_q <= 1'b1;
                    if (!bus.dnn_out_ready) begin
                        proto_err <= 1'b1;
                    end
                    state <= S_OUT_WAIT;
                end
                S_OUT_WAIT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        n           <= n + 2'd1;
                        if (n == 2'd3) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_L2_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        drive_x = (state == S_L1_ISSUE) || (state == S_L1_CAPT) ||
                  (state == S_L2_ISSUE) || (state == S_L2_DRIVE) ||
                  (state == S_L2_CAPT);
    end

    assign bus.feat_ready   = (state == S_LOAD);
    assign bus.dnn_in_ready = (state == S_L1_ISSUE) || (state == S_L2_ISSUE);

    assign bus.dnn_x0 = drive_x ? feat[n][0] : '0;
    assign bus.dnn_x1 = drive_x ? feat[n][1] : '0;
    assign bus.dnn_x2 = drive_x ? feat[n][2] : '0;
    assign bus.dnn_x3 = drive_x ? feat[n][3] : '0;

    assign bus.dnn_y4_aggr = agg[n][0];
    assign bus.dnn_y5_aggr = agg[n][1];
    assign bus.dnn_y6_aggr = agg[n][2];
    assign bus.dnn_y7_aggr = agg[n][3];

    assign bus.res_valid = res_valid_q;
    assign bus.res_node  = res_node_q;
    assign bus.res_out0  = res_out0_q;
    assign bus.res_out1  = res_out1_q;

endmodule
`default_nettype wire

// File: tb/tb_gnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_gnn_layer_sched
// Brief  : Self-checking bench with a datapath stub and a graph-level reference model
// Rev    : 1.0  initial release
// ============================================================================
module tb_gnn_layer_sched;
    import gnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] adj;
    logic        busy;
    logic        done;
    logic        proto_err;

    gnn_layer_sched_if bus ();

    gnn_layer_sched #(.AGGR_SELF(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .adj       (adj),
        .busy      (busy),
        .done      (done),
        .proto_err (proto_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc_cnt = 0;

    int   W1 [4][4];
    int   W2a [4];
    int   W2b [4];
    bit   ovr_en;
    int   ovr;
    bit   nordy;
    int   cur_feat [4][4];
    logic [15:0] cur_adj;
    int   hidm [4][4];
    int   aggm [4][4];
    int   e0 [4];
    int   e1 [4];

    typedef struct {
        int          fval [4];
        logic [15:0] adj;
        int          eout [4];
    } vec_t;
    vec_t vt [4];

    // Datapath stub: layer 1 answers one cycle after issue, layer 2 two cycles after issue.
    int xr [4];
    bit v1;
    int o0, o1;
    int ys [4];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        v1 <= bus.dnn_in_ready;
        if (bus.dnn_in_ready) begin
            xr[0] <= int'(bus.dnn_x0);
            xr[1] <= int'(bus.dnn_x1);
            xr[2] <= int'(bus.dnn_x2);
            xr[3] <= int'(bus.dnn_x3);
        end
        if (v1) begin
            o0 <= W2a[0]*int'(bus.dnn_y4_aggr) + W2a[1]*int'(bus.dnn_y5_aggr)
                + W2a[2]*int'(bus.dnn_y6_aggr) + W2a[3]*int'(bus.dnn_y7_aggr);
            o1 <= W2b[0]*int'(bus.dnn_y4_aggr) + W2b[1]*int'(bus.dnn_y5_aggr)
                + W2b[2]*int'(bus.dnn_y6_aggr) + W2b[3]*int'(bus.dnn_y7_aggr);
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ys[k] = ovr_en ? ovr : (W1[k][0]*xr[0] + W1[k][1]*xr[1] + W1[k][2]*xr[2] + W1[k][3]*xr[3]);
        end
    end

    assign bus.dnn_y4        = y_t'(ys[0]);
    assign bus.dnn_y5        = y_t'(ys[1]);
    assign bus.dnn_y6        = y_t'(ys[2]);
    assign bus.dnn_y7        = y_t'(ys[3]);
    assign bus.dnn_out0      = out_t'(o0);
    assign bus.dnn_out1      = out_t'(o1);
    assign bus.dnn_out_ready = ~nordy;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_done"},      int'(done), 0);
        check({tag, "_feat_rdy"},  int'(bus.feat_ready), 0);
        check({tag, "_in_rdy"},    int'(bus.dnn_in_ready), 0);
        check({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check({tag, "_proto_err"}, int'(proto_err), 0);
        check({tag, "_res_node"},  int'(bus.res_node), 0);
        check({tag, "_res_out0"},  int'(bus.res_out0), 0);
        check({tag, "_res_out1"},  int'(bus.res_out1), 0);
        check({tag, "_dnn_x"},     int'(|{bus.dnn_x0, bus.dnn_x1, bus.dnn_x2, bus.dnn_x3}), 0);
        check({tag, "_aggr"},      int'(|{bus.dnn_y4_aggr, bus.dnn_y5_aggr, bus.dnn_y6_aggr, bus.dnn_y7_aggr}), 0);
    endtask

    // Graph-level reference: hidden = W1*feature, aggregate over neighbours (+self), clamp, then W2.
    task automatic compute_expected();
        int s;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) begin
                s = 0;
                for (int i = 0; i < 4; i++) s += W1[k][i] * cur_feat[j][i];
                hidm[j][k] = ovr_en ? ovr : s;
            end
        for (int nn = 0; nn < 4; nn++) begin
            e0[nn] = 0;
            e1[nn] = 0;
            for (int k = 0; k < 4; k++) begin
                s = 0;
                for (int j = 0; j < 4; j++)
                    if (cur_adj[4*nn+j] || j == nn) s += hidm[j][k];
                aggm[nn][k] = (s > 4095) ? 4095 : ((s < -4096) ? -4096 : s);
                e0[nn] += W2a[k] * aggm[nn][k];
                e1[nn] += W2b[k] * aggm[nn][k];
            end
        end
    endtask

    task automatic set_ones();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) W1[k][i] = 1;
            W2a[k] = 1;
            W2b[k] = 1;
        end
    endtask

    task automatic rand_feat();
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) cur_feat[j][i] = int'($urandom_range(0, 63)) - 32;
    endtask

    // Runs one pass from a sample point (1 time unit after a rising edge) back to a sample point.
    task automatic do_pass(input int stall_node, input int stall_len, input bit gaps,
                           input bit glitch, input bit chk_lat, input int abort_at);
        int k = 0, c0, res_i = 0, dn = 0, stall_cnt = 0, viol = 0, inr = 0;
        int h_node = 0, h0 = 0, h1 = 0;
        bit pend = 0, seen = 0, aborted = 0;
        start = 1'b1;
        adj   = cur_adj;
        c0    = cyc_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int t = 0; t < 300; t++) begin
            if (pend) k++;
            pend = 0;
            if (bus.feat_ready && k < 4 && !(gaps && $urandom_range(0, 3) == 0)) begin
                bus.feat_valid = 1'b1;
                bus.feat_x0 = x_t'(cur_feat[k][0]);
                bus.feat_x1 = x_t'(cur_feat[k][1]);
                bus.feat_x2 = x_t'(cur_feat[k][2]);
                bus.feat_x3 = x_t'(cur_feat[k][3]);
                pend = 1;
            end else begin
                bus.feat_valid = 1'b0;
                bus.feat_x0 = x_t'($urandom);
                bus.feat_x1 = x_t'($urandom);
                bus.feat_x2 = x_t'($urandom);
                bus.feat_x3 = x_t'($urandom);
            end
            if (glitch) begin
                start = (cyc_cnt - c0 == 8);
                if (cyc_cnt - c0 == 8) adj = ~cur_adj;
            end
            if (bus.res_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (res_i > 3) begin
                        check("extra_result", res_i, 3);
                    end else begin
                        check("res_node", int'(bus.res_node), res_i);
                        check("res_out0", int'(bus.res_out0), e0[res_i]);
                        check("res_out1", int'(bus.res_out1), e1[res_i]);
                        check("aggr_lane0", int'(bus.dnn_y4_aggr), aggm[res_i][0]);
                        check("aggr_lane1", int'(bus.dnn_y5_aggr), aggm[res_i][1]);
                        check("aggr_lane2", int'(bus.dnn_y6_aggr), aggm[res_i][2]);
                        check("aggr_lane3", int'(bus.dnn_y7_aggr), aggm[res_i][3]);
                    end
                    if (res_i == 0 && chk_lat) check("latency", cyc_cnt - c0, 20);
                    h_node = int'(bus.res_node);
                    h0 = int'(bus.res_out0);
                    h1 = int'(bus.res_out1);
                end else if (int'(bus.res_node) != h_node || int'(bus.res_out0) != h0
                             || int'(bus.res_out1) != h1) begin
                    viol++;
                end
                if (bus.dnn_in_ready) inr++;
                if (int'(bus.res_node) == stall_node && stall_cnt < stall_len) begin
                    bus.res_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.res_ready = 1'b1;
                    res_i++;
                    seen = 0;
                end
            end else begin
                bus.res_ready = 1'($urandom_range(0, 1));
            end
            if (done) dn++;
            if (abort_at > 0 && cyc_cnt - c0 == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                aborted = 1;
            end
            if (dn > 0 || aborted) break;
            @(posedge clk); #1;
        end
        bus.res_ready  = 1'b0;
        bus.feat_valid = 1'b0;
        start = 1'b0;
        adj   = cur_adj;
        if (!aborted) begin
            check("done_pulse", dn, 1);
            check("n_results", res_i, 4);
            check("busy_in_done", int'(busy), 0);
            check("res_stable_stall", viol, 0);
            check("no_issue_while_res", inr, 0);
            if (stall_len > 0) check("stall_cycles", stall_cnt, stall_len);
            repeat (3) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            check("done_once", dn, 1);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        adj    = '0;
        ovr_en = 0;
        ovr    = 0;
        nordy  = 0;
        bus.feat_valid = 1'b0;
        bus.feat_x0 = '0;
        bus.feat_x1 = '0;
        bus.feat_x2 = '0;
        bus.feat_x3 = '0;
        bus.res_ready = 1'b0;
        set_ones();

        vt[0].fval = '{1, 1, 1, 1};     vt[0].adj = 16'h0000; vt[0].eout = '{16, 16, 16, 16};
        vt[1].fval = '{1, 2, 3, 4};     vt[1].adj = 16'h0000; vt[1].eout = '{16, 32, 48, 64};
        vt[2].fval = '{1, 2, 3, 4};     vt[2].adj = 16'hFFFF; vt[2].eout = '{160, 160, 160, 160};
        vt[3].fval = '{-1, -2, -3, -4}; vt[3].adj = 16'h4052; vt[3].eout = '{-48, -96, -48, -112};

        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("idle");

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++) cur_feat[j][i] = vt[v].fval[j];
            cur_adj = vt[v].adj;
            compute_expected();
            for (int nn = 0; nn < 4; nn++) begin
                e0[nn] = vt[v].eout[nn];
                e1[nn] = vt[v].eout[nn];
            end
            do_pass(-1, 0, 0, 0, 1, 0);
            check("proto_clean", int'(proto_err), 0);
        end

        // Saturation of the aggregate in both directions
        ovr_en = 1;
        ovr = 4000;
        cur_adj = 16'hFFFF;
        rand_feat();
        compute_expected();
        do_pass(-1, 0, 0, 0, 1, 0);
        ovr = -4000;
        compute_expected();
        do_pass(-1, 0, 0, 0, 1, 0);
        ovr_en = 0;

        // Result back-pressure at node 1, with a stray start and adj change during layer 1
        rand_feat();
        cur_adj = 16'($urandom);
        compute_expected();
        do_pass(1, 5, 0, 1, 1, 0);

        // Datapath not ready at layer-2 capture; error must persist over a later clean pass
        nordy = 1;
        rand_feat();
        cur_adj = 16'($urandom);
        compute_expected();
        do_pass(-1, 0, 0, 0, 1, 0);
        check("proto_err_set", int'(proto_err), 1);
        nordy = 0;
        rand_feat();
        compute_expected();
        do_pass(-1, 0, 0, 0, 1, 0);
        check("proto_err_sticky", int'(proto_err), 1);

        // Reset in the middle of aggregation, then a clean pass
        begin
            int dn2 = 0;
            rand_feat();
            cur_adj = 16'($urandom);
            compute_expected();
            do_pass(-1, 0, 0, 0, 0, 15);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (6) begin
                @(posedge clk); #1;
                if (done) dn2++;
            end
            check("no_done_after_abort", dn2, 0);
            check("idle_after_abort", int'(busy), 0);
            rand_feat();
            compute_expected();
            do_pass(-1, 0, 0, 0, 1, 0);
        end

        // Randomised passes with random weights, load gaps, stalls and stray starts
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 4; i++) W1[k][i] = int'($urandom_range(0, 6)) - 3;
                W2a[k] = int'($urandom_range(0, 6)) - 3;
                W2b[k] = int'($urandom_range(0, 6)) - 3;
            end
            rand_feat();
            cur_adj = 16'($urandom);
            compute_expected();
            do_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1,
                    1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
